// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result path: op codes, converter
// FSM states and the BCD digit type.
package calc_pkg;

   // Op codes carried alongside every arithmetic result
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // Binary-to-BCD converter sequencing
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // One packed decimal digit
   typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit. The
// add stays inside the nibble and never carries out.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  bcd_t din,
   output bcd_t dout
);

   // Add-3 correction applied before each shift
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter for the calculator result path.
// One double-dabble step per clock: IN_W shift cycles plus one cycle to
// publish the digits. A guard digit above the NDIG displayed digits flags
// magnitudes that do not fit on the display.
module bin_to_bcd_seq
   import calc_pkg::*;
#(
   parameter int IN_W = 14,
   parameter int NDIG = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      en,
   input  logic [IN_W-1:0] num,
   output logic            busy,
   output logic            done,
   output logic [3:0]      dig3,
   output logic [3:0]      dig2,
   output logic [3:0]      dig1,
   output logic [3:0]      dig0,
   output logic            neg,
   output logic            ovf
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * (NDIG + 1);

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [BCD_W-1:0]        bcd_q;
   logic [IN_W-1:0]         mag_q;
   logic                    neg_q;
   logic                    lost_q;

   logic signed [IN_W-1:0]  num_s;
   logic                    is_neg;
   logic [IN_W-1:0]         mag_in;
   logic [BCD_W-1:0]        bcd_adj;

   // Only subtraction results are two's complement; negation wraps in IN_W
   // bits so the most negative input becomes +2^(IN_W-1).
   assign num_s  = num;
   assign is_neg = (en == OP_SUB) && num[IN_W-1];
   assign mag_in = is_neg ? $unsigned(-num_s) : num;

   // Add-3 correction on every accumulator digit, guard digit included
   for (genvar g = 0; g < NDIG + 1; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   // Conversion sequencer: capture operands, run IN_W shift steps, publish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bcd_q   <= '0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         lost_q  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mag_q   <= mag_in;
                  neg_q   <= is_neg;
                  bcd_q   <= '0;
                  lost_q  <= 1'b0;
                  cnt_q   <= CNT_W'(IN_W);
                  busy    <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               // A bit falling off the guard digit only happens if IN_W is
               // raised beyond what the guard covers; keep it as overflow.
               bcd_q  <= {bcd_adj[BCD_W-2:0], mag_q[IN_W-1]};
               lost_q <= lost_q | bcd_adj[BCD_W-1];
               mag_q  <= {mag_q[IN_W-2:0], 1'b0};
               cnt_q  <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Result registers: updated only on the publish cycle, otherwise held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
         dig3 <= '0;
         dig2 <= '0;
         dig1 <= '0;
         dig0 <= '0;
         neg  <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         done <= (state_q == FINISH);
         if (state_q == FINISH) begin
            dig3 <= bcd_q[15:12];
            dig2 <= bcd_q[11:8];
            dig1 <= bcd_q[7:4];
            dig0 <= bcd_q[3:0];
            neg  <= neg_q;
            ovf  <= (bcd_q[4*NDIG +: 4] != 4'd0) || lost_q;
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed cases plus random operands, all
// compared against a decimal reference computed with integer arithmetic.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  en;
   logic [13:0] num;
   logic        busy;
   logic        done;
   logic [3:0]  dig3, dig2, dig1, dig0;
   logic        neg;
   logic        ovf;

   int          n_vec = 0;
   int          n_err = 0;
   logic [17:0] prev_res;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.IN_W(14), .NDIG(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .en    (en),
      .num   (num),
      .busy  (busy),
      .done  (done),
      .dig3  (dig3),
      .dig2  (dig2),
      .dig1  (dig1),
      .dig0  (dig0),
      .neg   (neg),
      .ovf   (ovf)
   );

   // Observed result packed as {ovf, neg, dig3, dig2, dig1, dig0}
   function automatic logic [17:0] res_now();
      return {ovf, neg, dig3, dig2, dig1, dig0};
   endfunction

   // Reference: signed value from op code, then decimal digits by div/mod
   function automatic logic [17:0] model(input logic [1:0] e, input logic [13:0] n);
      int          v;
      bit          ng;
      logic [17:0] r;
      ng = (e == 2'b01) && n[13];
      v  = ng ? (16384 - int'(n)) : int'(n);
      r[17]    = (v > 9999);
      r[16]    = ng;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // One conversion; optional glitching of inputs and start while busy
   task automatic run_conv(input string tag, input logic [1:0] e, input logic [13:0] n,
                           input bit glitch);
      int          edges;
      logic [17:0] exp;
      exp = model(e, n);
      @(negedge clk);
      en    = e;
      num   = n;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      edges = 0;
      while (!done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 5) chk({tag, "_hold"}, res_now(), prev_res);
         if (glitch) begin
            en    = 2'($urandom);
            num   = 14'($urandom);
            start = (edges == 3) || (edges == 10);
         end
      end
      start = 1'b0;
      chk({tag, "_lat"}, edges, 15);
      chk({tag, "_res"}, res_now(), exp);
      prev_res = exp;
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {busy, done}, 0);
   endtask

   initial begin
      int edges;
      int seen;

      rst   = 1'b1;
      start = 1'b0;
      en    = 2'b00;
      num   = '0;
      #1;
      chk("reset", {busy, done, res_now()}, 0);
      prev_res = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_conv("mul9801", 2'b10, 14'd9801, 1'b0);
      run_conv("sub_m1", 2'b01, 14'h3FFF, 1'b0);
      run_conv("sub_m99", 2'b01, 14'h3F9D, 1'b0);
      run_conv("add0", 2'b00, 14'd0, 1'b0);
      run_conv("add12345", 2'b00, 14'd12345, 1'b0);
      run_conv("max", 2'b11, 14'h3FFF, 1'b0);
      run_conv("sub_pos", 2'b01, 14'd1999, 1'b0);
      run_conv("busy4321", 2'b00, 14'd4321, 1'b1);

      // Asynchronous abort partway through the shift phase
      @(negedge clk);
      en    = 2'b00;
      num   = 14'd1234;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", {busy, done, res_now()}, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("rst_nodone", seen, 0);
      prev_res = '0;
      run_conv("after_rst42", 2'b00, 14'd42, 1'b0);

      // start held high: two conversions back to back
      @(negedge clk);
      en    = 2'b00;
      num   = 14'd1111;
      start = 1'b1;
      @(posedge clk);
      #1;
      num   = 14'd2222;
      edges = 0;
      while (!done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk("b2b1_lat", edges, 15);
      chk("b2b1_res", res_now(), model(2'b00, 14'd1111));
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!done && edges < 40);
      start = 1'b0;
      chk("b2b2_gap", edges, 16);
      chk("b2b2_res", res_now(), model(2'b00, 14'd2222));
      prev_res = model(2'b00, 14'd2222);
      @(posedge clk);
      #1;
      chk("b2b_idle", {busy, done}, 0);

      run_conv("sub_min", 2'b01, 14'h2000, 1'b0);

      repeat (24) begin
         run_conv("rnd", 2'($urandom), 14'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
